disp_manager: RTL and testbench

- Display stage fed by the clock-domain-crossing buffer's read side. Runs on the consumer clock.
- Accepts 16-bit result words from the Fibonacci or timer path with a valid/ready handshake.
- Converts each word to 5 BCD digits with a sequential double-dabble converter.
- Time-multiplexes an 8-digit active-low 7-segment display showing the value, the source-module glyph and the selected prog setting.

---
 rtl/disp_manager_if.sv | 11 +
 rtl/disp_manager.sv | 135 +++++++++++++
 tb/tb_disp_manager.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_manager_if.sv
// Word handshake between the CDC read side and the display stage.
// valid/ready: a word transfers on a rising clk edge where data_valid && data_ready; data is held while valid and not ready.
interface disp_manager_if;
  logic        data_valid;
  logic [15:0] data;
  logic        data_ready;
  logic [1:0]  dbg_state;

  modport master (output data_valid, output data, input data_ready, input dbg_state);
  modport slave  (input data_valid, input data, output data_ready, output dbg_state);
endinterface

// File: rtl/disp_manager.sv
// Display stage: double-dabble BCD conversion and 8-digit active-low 7-segment scan.
// Optional macro LZ_BLANK_EN blanks leading zeros in value digits 4..1.
module disp_manager #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           prog,
  input  logic [1:0]           module_sel,
  disp_manager_if.slave        bus,
  output logic [7:0]           an,
  output logic [7:0]           dec_ddp
);
  localparam int CW = $clog2(REFRESH_DIV + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1, S_COMMIT = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [15:0]   bin_q, bin_d;
  logic [19:0]   bcd_q, bcd_d, adj;
  logic [19:0]   disp_q, disp_d;
  logic [CW-1:0] ref_q, ref_d;
  logic [2:0]    scan_q, scan_d;
  logic [7:0]    an_q, an_d, seg_q, seg_d;
  logic [4:1]    lz;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 8'h03;
      4'd1: glyph = 8'h9F;
      4'd2: glyph = 8'h25;
      4'd3: glyph = 8'h0D;
      4'd4: glyph = 8'h99;
      4'd5: glyph = 8'h49;
      4'd6: glyph = 8'h41;
      4'd7: glyph = 8'h1F;
      4'd8: glyph = 8'h01;
      4'd9: glyph = 8'h09;
      default: glyph = 8'hFF;
    endcase
  endfunction

  assign bus.data_ready = (state_q == S_IDLE);
  assign bus.dbg_state  = state_q;
  assign an      = an_q;
  assign dec_ddp = seg_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    adj     = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (bus.data_valid) begin
          bin_d   = bus.data;
          bcd_d   = '0;
          cnt_d   = 5'd16;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        for (int i = 0; i < 5; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d  = bcd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Leading-zero mask derived from the committed value only.
  always_comb begin
    lz = '0;
`ifdef LZ_BLANK_EN
    lz[4] = (disp_q[19:16] == 4'd0);
    lz[3] = lz[4] && (disp_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
`endif
  end

  always_comb begin
    ref_d  = ref_q + CW'(1);
    scan_d = scan_q;
    if (ref_q == CW'(REFRESH_DIV - 1)) begin
      ref_d  = '0;
      scan_d = scan_q + 3'd1;
    end
    an_d = ~(8'h01 << scan_q);
    case (scan_q)
      3'd0: seg_d = glyph(disp_q[3:0]);
      3'd1: seg_d = lz[1] ? 8'hFF : glyph(disp_q[7:4]);
      3'd2: seg_d = lz[2] ? 8'hFF : glyph(disp_q[11:8]);
      3'd3: seg_d = lz[3] ? 8'hFF : glyph(disp_q[15:12]);
      3'd4: seg_d = lz[4] ? 8'hFF : glyph(disp_q[19:16]);
      3'd6: seg_d = (module_sel == 2'd1) ? 8'h71 : (module_sel == 2'd2) ? 8'hE1 : 8'hFF;
      3'd7: seg_d = glyph({1'b0, prog});
      default: seg_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      ref_q   <= '0;
      scan_q  <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      ref_q   <= ref_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end
endmodule

// File: tb/tb_disp_manager.sv
// Self-checking bench for disp_manager with REFRESH_DIV=4 and a decimal reference model.
module tb_disp_manager;
  localparam int DIV = 4;
  localparam int NCAP = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] prog;
  logic [1:0] module_sel;
  logic [7:0] an, dec_ddp;

  disp_manager_if bus();

  disp_manager #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .prog(prog), .module_sel(module_sel),
    .bus(bus), .an(an), .dec_ddp(dec_ddp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  int cur_val = 0;
  logic [7:0] cap_an[NCAP];
  logic [7:0] cap_seg[NCAP];

  function automatic logic [7:0] model_glyph(input int d);
    case (d)
      0: return 8'h03; 1: return 8'h9F; 2: return 8'h25; 3: return 8'h0D; 4: return 8'h99;
      5: return 8'h49; 6: return 8'h41; 7: return 8'h1F; 8: return 8'h01; 9: return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int idx, input int value, input int pr, input int ms);
    int p10 = 1;
    if (idx <= 4) begin
      for (int k = 0; k < idx; k++) p10 = p10 * 10;
`ifdef LZ_BLANK_EN
      if (idx > 0 && value < p10) return 8'hFF;
`endif
      return model_glyph((value / p10) % 10);
    end
    if (idx == 5) return 8'hFF;
    if (idx == 6) return (ms == 1) ? 8'h71 : (ms == 2) ? 8'hE1 : 8'hFF;
    return model_glyph(pr);
  endfunction

  function automatic int an_to_idx(input logic [7:0] a);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m = ~(8'h01 << i);
      if (a === m) return i;
    end
    return -1;
  endfunction

  task automatic send(input logic [15:0] v);
    int t = 0;
    while (bus.data_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 100) begin
      n_fail++;
      $display("FAIL send_wait: data_ready=%b required 1 within 100 cycles", bus.data_ready);
    end
    @(negedge clk);
    bus.data_valid = 1'b1;
    bus.data = v;
    exp_q.push_back(v);
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
  endtask

  // Counts negedges with data_ready low after an accept; returns when ready is back.
  task automatic wait_ready(output int low_cycles);
    low_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.data_ready === 1'b1) break;
      low_cycles++;
    end
    @(negedge clk);
  endtask

  task automatic capture();
    for (int i = 0; i < NCAP; i++) begin
      @(negedge clk);
      cap_an[i]  = an;
      cap_seg[i] = dec_ddp;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (an !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h required FF", an); end
    n_checks++;
    if (dec_ddp !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h required FF", dec_ddp); end
    n_checks++;
    if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.data_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (an !== 8'hFE) begin n_fail++; $display("FAIL reset_first_digit: an got %h required FE", an); end
    cur_val = 0;
    exp_q.delete();
  endtask

  task automatic test_accept_1234();
    int low, idx, prev_idx, run;
    bit seen;
    prog = 3'd0; module_sel = 2'd1;
    send(16'd1234);
    wait_ready(low);
    n_checks++;
    if (low !== 17) begin n_fail++; $display("FAIL accept_ready_low: got %0d cycles required 17", low); end
    cur_val = int'(exp_q.pop_front());
    capture();
    seen = 0; run = 1; prev_idx = an_to_idx(cap_an[0]);
    for (int i = 0; i < NCAP; i++) begin
      idx = an_to_idx(cap_an[i]);
      n_checks++;
      if (idx < 0 || cap_seg[i] !== model_seg(idx, cur_val, 0, 1)) begin
        n_fail++;
        $display("FAIL accept_digit: an=%h seg=%h required %h", cap_an[i], cap_seg[i], model_seg(idx < 0 ? 0 : idx, cur_val, 0, 1));
      end
      if (i > 0 && cap_an[i] !== cap_an[i-1]) begin
        n_checks++;
        if (idx !== (prev_idx + 1) % 8) begin n_fail++; $display("FAIL accept_step: idx %0d after %0d", idx, prev_idx); end
        if (seen) begin
          n_checks++;
          if (run !== DIV) begin n_fail++; $display("FAIL accept_dwell: got %0d cycles required %0d", run, DIV); end
        end
        seen = 1; run = 1; prev_idx = idx;
      end else if (i > 0) run++;
    end
  endtask

  task automatic test_max();
    int low, idx;
    bit wrap;
    send(16'd65535);
    wait_ready(low);
    cur_val = int'(exp_q.pop_front());
    capture();
    wrap = 0;
    for (int i = 0; i < NCAP; i++) begin
      idx = an_to_idx(cap_an[i]);
      n_checks++;
      if (idx < 0 || cap_seg[i] !== model_seg(idx, cur_val, int'(prog), int'(module_sel))) begin
        n_fail++;
        $display("FAIL max_digit: an=%h seg=%h", cap_an[i], cap_seg[i]);
      end
      if (i > 0 && cap_an[i-1] === 8'h7F && cap_an[i] === 8'hFE) wrap = 1;
    end
    n_checks++;
    if (!wrap) begin n_fail++; $display("FAIL max_wrap: wrap seen %0d required 1", wrap); end
  endtask

  task automatic test_busy_drop();
    int rises, idx;
    logic prev;
    send(16'd1234);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2)  begin bus.data_valid = 1'b1; bus.data = 16'd42; end
      if (i == 12) bus.data_valid = 1'b0;
      if (bus.data_ready === 1'b1 && prev === 1'b0) rises++;
      prev = bus.data_ready;
    end
    n_checks++;
    if (rises !== 1) begin n_fail++; $display("FAIL busy_rises: got %0d required 1", rises); end
    cur_val = int'(exp_q.pop_front());
    capture();
    for (int i = 0; i < NCAP; i++) begin
      idx = an_to_idx(cap_an[i]);
      n_checks++;
      if (idx < 0 || cap_seg[i] !== model_seg(idx, cur_val, int'(prog), int'(module_sel))) begin
        n_fail++;
        $display("FAIL busy_digit: an=%h seg=%h", cap_an[i], cap_seg[i]);
      end
    end
  endtask

  task automatic test_glyphs();
    int idx;
    prog = 3'd5;
    for (int ms = 0; ms < 4; ms++) begin
      @(negedge clk);
      module_sel = 2'(ms);
      @(negedge clk);
      capture();
      for (int i = 0; i < NCAP; i++) begin
        idx = an_to_idx(cap_an[i]);
        n_checks++;
        if (idx < 0 || cap_seg[i] !== model_seg(idx, cur_val, 5, ms)) begin
          n_fail++;
          $display("FAIL glyph_sel%0d: an=%h seg=%h", ms, cap_an[i], cap_seg[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    int idx;
    send(16'd999);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.data_ready !== 1'b1 || an !== 8'hFF || dec_ddp !== 8'hFF) begin
      n_fail++;
      $display("FAIL midconv_reset: ready=%b an=%h seg=%h required 1 FF FF", bus.data_ready, an, dec_ddp);
    end
    exp_q.delete();
    cur_val = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    capture();
    for (int i = 0; i < NCAP; i++) begin
      idx = an_to_idx(cap_an[i]);
      n_checks++;
      if (idx < 0 || cap_seg[i] !== model_seg(idx, cur_val, int'(prog), int'(module_sel))) begin
        n_fail++;
        $display("FAIL midconv_digit: an=%h seg=%h", cap_an[i], cap_seg[i]);
      end
    end
    n_checks++;
    if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL midconv_ready: got %b required 1", bus.data_ready); end
  endtask

  task automatic test_random();
    int low, idx;
    for (int n = 0; n < 6; n++) begin
      prog = 3'($urandom_range(0, 7));
      module_sel = 2'($urandom_range(0, 3));
      send(16'($urandom_range(0, 65535)));
      wait_ready(low);
      n_checks++;
      if (low !== 17) begin n_fail++; $display("FAIL random_ready_low: got %0d required 17", low); end
      cur_val = int'(exp_q.pop_front());
      capture();
      for (int i = 0; i < NCAP; i++) begin
        idx = an_to_idx(cap_an[i]);
        n_checks++;
        if (idx < 0 || cap_seg[i] !== model_seg(idx, cur_val, int'(prog), int'(module_sel))) begin
          n_fail++;
          $display("FAIL random_digit: value=%0d an=%h seg=%h", cur_val, cap_an[i], cap_seg[i]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    prog = 3'd0;
    module_sel = 2'd0;
    bus.data_valid = 1'b0;
    bus.data = 16'd0;
    test_reset();
    test_accept_1234();
    test_max();
    test_busy_drop();
    test_glyphs();
    test_reset_mid_conv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
